regfile_mp: RTL and testbench

Parametrised multi-port general-purpose register file with an integrated pending-write scoreboard. It replaces the fixed 32x32, 2-read/1-write register file in the decode stage. It adds configurable width, depth and port counts, asynchronous clearing of all registers, and per-register busy tracking so decode can stall on outstanding producers.

---
 rtl/regfile_mp_if.sv | 33 +++
 rtl/regfile_mp.sv | 91 +++++++++
 tb/tb_regfile_mp.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// Bundle of write, read and scoreboard signals for regfile_mp.
// Latency: none (wires only); bus widths follow the parameters.
// Backpressure: none, every signal is accepted each cycle.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2,
    parameter int NWR    = 2
);
    logic [NWR-1:0]        we;
    logic [NWR*ADDR_W-1:0] waddr;
    logic [NWR*DATA_W-1:0] wdata;
    logic [NRD-1:0]        re;
    logic [NRD*ADDR_W-1:0] raddr;
    logic [NRD*DATA_W-1:0] rdata;
    logic [NRD-1:0]        rd_pend;
    logic                  iss_v;
    logic [ADDR_W-1:0]     iss_addr;
    logic                  flush;
    logic                  any_pend;

    // decode stage side: drives writes, reads and issues
    modport master (
        output we, waddr, wdata, re, raddr, iss_v, iss_addr, flush,
        input  rdata, rd_pend, any_pend
    );

    // register file side
    modport slave (
        input  we, waddr, wdata, re, raddr, iss_v, iss_addr, flush,
        output rdata, rd_pend, any_pend
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file (r0 hardwired zero) with per-register pending-write scoreboard.
// Latency: writes/pend updates visible the cycle after the edge; reads combinational.
// Backpressure: none; optional same-cycle write bypass when REGFILE_BYPASS_EN is defined.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2,
    parameter int NWR    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    regfile_mp_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic [DEPTH-1:0]  pend_nxt;

    // storage: later ports are younger, so their non-blocking write lands last and wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < DEPTH; a++) begin
                regs[a] <= '0;
            end
        end else begin
            for (int i = 0; i < NWR; i++) begin
                if (bus.we[i] && (bus.waddr[i*ADDR_W +: ADDR_W] != '0)) begin
                    regs[bus.waddr[i*ADDR_W +: ADDR_W]] <= bus.wdata[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // scoreboard next state: writes clear, a same-cycle issue re-sets, flush clears everything
    always_comb begin
        pend_nxt = pend;
        for (int i = 0; i < NWR; i++) begin
            if (bus.we[i]) begin
                pend_nxt[bus.waddr[i*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (bus.iss_v) begin
            pend_nxt[bus.iss_addr] = 1'b1;
        end
        if (bus.flush) begin
            pend_nxt = '0;
        end
        pend_nxt[0] = 1'b0;
    end

    // scoreboard register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

    assign bus.any_pend = rst_n && (|pend);

    for (genvar j = 0; j < NRD; j++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] val;
        logic              hit;
        logic              active;

        assign ra     = bus.raddr[j*ADDR_W +: ADDR_W];
        assign active = rst_n && bus.re[j] && (ra != '0);

        // read value: storage, optionally overridden by the youngest matching write
        always_comb begin
            val = regs[ra];
            hit = 1'b0;
`ifdef REGFILE_BYPASS_EN
            for (int i = 0; i < NWR; i++) begin
                if (bus.we[i] && (bus.waddr[i*ADDR_W +: ADDR_W] == ra)) begin
                    hit = 1'b1;
                    val = bus.wdata[i*DATA_W +: DATA_W];
                end
            end
`endif
        end

        // a bypassed producer is no longer outstanding unless a newer one issues this cycle
        assign bus.rdata[j*DATA_W +: DATA_W] = active ? val : '0;
        assign bus.rd_pend[j] = active && pend[ra] &&
                                !(hit && !(bus.iss_v && (bus.iss_addr == ra)));
    end
endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NRD(2), .NWR(2)) ifa ();
    regfile_mp_if #(.DATA_W(16), .ADDR_W(3), .NRD(4), .NWR(1)) ifb ();

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .NWR(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    regfile_mp #(.DATA_W(16), .ADDR_W(3), .NRD(4), .NWR(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // kind: 0 = A rdata, 1 = A rd_pend, 2 = A any_pend, 3 = B rdata
    typedef struct {
        int          kind;
        int          port;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t expq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic void expect_v(int kind, int port, logic [31:0] val, string name);
        exp_t e;
        e.kind = kind;
        e.port = port;
        e.val  = val;
        e.name = name;
        expq.push_back(e);
    endfunction

    // monitor: outputs settle mid-cycle, drain every expectation queued for this cycle
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (expq.size() > 0) begin
            e = expq.pop_front();
            case (e.kind)
                0:       act = ifa.rdata[e.port*32 +: 32];
                1:       act = {31'd0, ifa.rd_pend[e.port]};
                2:       act = {31'd0, ifa.any_pend};
                default: act = {16'd0, ifb.rdata[e.port*16 +: 16]};
            endcase
            n_cmp++;
            if (act !== e.val) begin
                n_err++;
                $display("FAIL %s: got %h, expected %h", e.name, act, e.val);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        ifa.we = '0; ifa.iss_v = 1'b0; ifa.flush = 1'b0;
        ifb.we = '0;
    endtask

    initial begin
        ifa.we = '0; ifa.waddr = '0; ifa.wdata = '0;
        ifa.re = '0; ifa.raddr = '0;
        ifa.iss_v = 1'b0; ifa.iss_addr = '0; ifa.flush = 1'b0;
        ifb.we = '0; ifb.waddr = '0; ifb.wdata = '0;
        ifb.re = '0; ifb.raddr = '0;
        ifb.iss_v = 1'b0; ifb.iss_addr = '0; ifb.flush = 1'b0;

        // C0: in reset
        #1;
        ifa.re = 2'b01; ifa.raddr = {5'd0, 5'd5};
        expect_v(0, 0, 32'h0, "reset_rdata");
        expect_v(1, 0, 32'h0, "reset_rd_pend");
        expect_v(2, 0, 32'h0, "reset_any_pend");

        // C1: release, write r5, issue r6
        step();
        rst_n = 1'b1;
        ifa.re = '0;
        ifa.we = 2'b01; ifa.waddr = {5'd0, 5'd5}; ifa.wdata = {32'h0, 32'hDEADBEEF};
        ifa.iss_v = 1'b1; ifa.iss_addr = 5'd6;

        // C2: r5 readable, r6 pending; then reset mid-cycle
        step();
        ifa.re = 2'b01; ifa.raddr = {5'd0, 5'd5};
        expect_v(0, 0, 32'hDEADBEEF, "r5_written");
        expect_v(2, 0, 32'h1, "any_pend_r6");
        @(negedge clk);
        #2;
        rst_n = 1'b0;

        // C3: still in reset
        step();
        expect_v(0, 0, 32'h0, "r5_in_reset");
        expect_v(2, 0, 32'h0, "any_pend_in_reset");

        // C4: released, r5 stays cleared; start B writes
        step();
        rst_n = 1'b1;
        expect_v(0, 0, 32'h0, "r5_after_reset");
        ifb.we = 1'b1; ifb.waddr = 3'd1; ifb.wdata = 16'h1111;

        // C5: dual write to r7, port 1 wins
        step();
        ifa.we = 2'b11; ifa.waddr = {5'd7, 5'd7}; ifa.wdata = {32'h22, 32'h11};
        ifa.re = 2'b01; ifa.raddr = {5'd0, 5'd7};
        expect_v(0, 0, BYP ? 32'h22 : 32'h0, "r7_same_cycle");
        ifb.we = 1'b1; ifb.waddr = 3'd2; ifb.wdata = 16'h2222;

        // C6: r7 = 0x22; write and issue to r0
        step();
        ifa.re = 2'b11; ifa.raddr = {5'd0, 5'd7};
        ifa.we = 2'b01; ifa.waddr = {5'd0, 5'd0}; ifa.wdata = {32'h0, 32'h55};
        ifa.iss_v = 1'b1; ifa.iss_addr = 5'd0;
        expect_v(0, 0, 32'h22, "r7_dual_write");
        expect_v(0, 1, 32'h0, "r0_bypass_blocked");
        expect_v(1, 1, 32'h0, "r0_pend_same");
        ifb.we = 1'b1; ifb.waddr = 3'd3; ifb.wdata = 16'h3333;

        // C7: r0 stays zero, never pending
        step();
        expect_v(0, 1, 32'h0, "r0_reads_zero");
        expect_v(1, 1, 32'h0, "r0_not_pending");
        expect_v(2, 0, 32'h0, "any_pend_r0");
        ifb.we = 1'b1; ifb.waddr = 3'd4; ifb.wdata = 16'h4444;

        // C8: issue r3; B reads four registers
        step();
        ifa.iss_v = 1'b1; ifa.iss_addr = 5'd3;
        ifb.re = 4'b1111; ifb.raddr = {3'd1, 3'd2, 3'd3, 3'd4};
        expect_v(3, 0, 32'h4444, "b_port0");
        expect_v(3, 1, 32'h3333, "b_port1");
        expect_v(3, 2, 32'h2222, "b_port2");
        expect_v(3, 3, 32'h1111, "b_port3");

        // C9: write r3 and read it the same cycle
        step();
        ifb.re = 4'b1011;
        expect_v(3, 2, 32'h0, "b_port2_disabled");
        expect_v(3, 3, 32'h1111, "b_port3_again");
        ifa.we = 2'b01; ifa.waddr = {5'd0, 5'd3}; ifa.wdata = {32'h0, 32'hA5A5A5A5};
        ifa.re = 2'b01; ifa.raddr = {5'd0, 5'd3};
        expect_v(0, 0, BYP ? 32'hA5A5A5A5 : 32'h0, "r3_same_cycle");
        expect_v(1, 0, BYP ? 32'h0 : 32'h1, "r3_pend_same_cycle");
        expect_v(2, 0, 32'h1, "any_pend_r3");

        // C10: r3 written, pend cleared
        step();
        expect_v(0, 0, 32'hA5A5A5A5, "r3_next_cycle");
        expect_v(1, 0, 32'h0, "r3_pend_cleared");
        expect_v(2, 0, 32'h0, "any_pend_r3_clr");

        // C11: issue r9
        step();
        ifa.iss_v = 1'b1; ifa.iss_addr = 5'd9;
        ifa.re = 2'b10; ifa.raddr = {5'd9, 5'd0};
        expect_v(1, 1, 32'h0, "r9_pend_same_cycle");
        expect_v(2, 0, 32'h0, "any_pend_r9_same");

        // C12: r9 pending, written on port 1
        step();
        expect_v(1, 1, 32'h1, "r9_pending");
        expect_v(2, 0, 32'h1, "any_pend_r9");
        ifa.we = 2'b10; ifa.waddr = {5'd9, 5'd0}; ifa.wdata = {32'h99, 32'h0};
        expect_v(1, 1, BYP ? 32'h0 : 32'h1, "r9_pend_write_cycle");
        expect_v(0, 1, BYP ? 32'h99 : 32'h0, "r9_data_write_cycle");

        // C13: r9 cleared
        step();
        expect_v(1, 1, 32'h0, "r9_pend_cleared");
        expect_v(2, 0, 32'h0, "any_pend_r9_clr");
        expect_v(0, 1, 32'h99, "r9_data");

        // C14: issue and write r4 together
        step();
        ifa.re = 2'b01; ifa.raddr = {5'd0, 5'd4};
        ifa.iss_v = 1'b1; ifa.iss_addr = 5'd4;
        ifa.we = 2'b01; ifa.waddr = {5'd0, 5'd4}; ifa.wdata = {32'h0, 32'h44};

        // C15: set beats write-clear
        step();
        expect_v(1, 0, 32'h1, "r4_set_wins");
        expect_v(2, 0, 32'h1, "any_pend_r4");
        expect_v(0, 0, 32'h44, "r4_data");
        ifa.flush = 1'b1;

        // C16: flushed; now issue r4 with flush
        step();
        expect_v(1, 0, 32'h0, "r4_flushed");
        ifa.iss_v = 1'b1; ifa.iss_addr = 5'd4; ifa.flush = 1'b1;

        // C17: flush beats set
        step();
        expect_v(1, 0, 32'h0, "r4_flush_wins");
        expect_v(2, 0, 32'h0, "any_pend_flush");

        // C18: read disabled
        step();
        ifa.re = 2'b00;
        expect_v(0, 0, 32'h0, "re_disabled");

        @(negedge clk);
        #2;
        if (expq.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, expected 0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end
endmodule
